mem_wb_stage: RTL

//  MEM/WB pipeline register plus writeback logic; the writer end of the register-file write port read by id_stage.

---
 rtl/mips_pkg.sv | 16 +
 rtl/load_extender.sv | 49 ++++
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the MIPS writeback path.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Little-endian byte/half extraction with sign or zero extension.
// Revision    : 1.0
// ============================================================================
module load_extender
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_load_size,
    input  logic                  i_load_unsigned,
    input  logic [1:0]            i_byte_offset,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_byte_fill;
    logic        w_half_fill;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_byte_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Bit 0 of the offset is ignored for halves; misalignment traps upstream.
    assign w_half      = i_byte_offset[1] ? i_word[31:16] : i_word[15:0];
    assign w_byte_fill = ~i_load_unsigned & w_byte[7];
    assign w_half_fill = ~i_load_unsigned & w_half[15];

    always_comb begin
        o_value = i_word;
        case (i_load_size)
            LOAD_BYTE: o_value = {{(DATA_WIDTH-8){w_byte_fill}}, w_byte};
            LOAD_HALF: o_value = {{(DATA_WIDTH-16){w_half_fill}}, w_half};
            default:   o_value = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register, writeback mux and retire counter.
// Revision    : 1.0
// ============================================================================
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic                      i_reg_write,
    input  logic                      i_mem_to_reg,
    input  logic                      i_link,
    input  logic [1:0]                i_load_size,
    input  logic                      i_load_unsigned,
    input  logic [1:0]                i_byte_offset,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_mem_read_data,
    input  logic [DATA_WIDTH-1:0]     i_return_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_write_register,
    output logic                      o_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] o_write_register,
    output logic [DATA_WIDTH-1:0]     o_write_data,
    output logic                      o_wb_valid,
    output logic [CNT_WIDTH-1:0]      o_instret
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                      r_valid;
    logic                      r_reg_write;
    logic                      r_mem_to_reg;
    logic                      r_link;
    logic [1:0]                r_load_size;
    logic                      r_load_unsigned;
    logic [1:0]                r_byte_offset;
    logic [DATA_WIDTH-1:0]     r_alu_result;
    logic [DATA_WIDTH-1:0]     r_mem_read_data;
    logic [DATA_WIDTH-1:0]     r_return_addr;
    logic [REG_ADDR_WIDTH-1:0] r_write_register;
    logic [CNT_WIDTH-1:0]      r_instret;

    logic [DATA_WIDTH-1:0]     w_load_value;
    logic                      w_retire;
    logic                      w_load_en;

    // Flush overrides stall, so a flushed edge still loads (payload is don't-care).
    assign w_load_en = i_flush | ~i_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid          <= 1'b0;
            r_reg_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_link           <= 1'b0;
            r_load_size      <= 2'b00;
            r_load_unsigned  <= 1'b0;
            r_byte_offset    <= 2'b00;
            r_alu_result     <= '0;
            r_mem_read_data  <= '0;
            r_return_addr    <= '0;
            r_write_register <= '0;
        end else if (w_load_en) begin
            r_valid          <= i_valid & ~i_flush;
            r_reg_write      <= i_reg_write;
            r_mem_to_reg     <= i_mem_to_reg;
            r_link           <= i_link;
            r_load_size      <= i_load_size;
            r_load_unsigned  <= i_load_unsigned;
            r_byte_offset    <= i_byte_offset;
            r_alu_result     <= i_alu_result;
            r_mem_read_data  <= i_mem_read_data;
            r_return_addr    <= i_return_addr;
            r_write_register <= i_write_register;
        end
    end

    // The occupant leaves whenever the register is overwritten.
    assign w_retire = r_valid & w_load_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + c_cnt_one;
        end
    end

    load_extender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extender (
        .i_load_size     (r_load_size),
        .i_load_unsigned (r_load_unsigned),
        .i_byte_offset   (r_byte_offset),
        .i_word          (r_mem_read_data),
        .o_value         (w_load_value)
    );

    always_comb begin
        o_write_data = r_alu_result;
        if (r_link) begin
            o_write_data = r_return_addr;
        end else if (r_mem_to_reg) begin
            o_write_data = w_load_value;
        end
    end

    assign o_reg_write      = r_valid & r_reg_write &
                              (r_write_register != REG_ADDR_WIDTH'(REG_ZERO));
    assign o_write_register = r_write_register;
    assign o_wb_valid       = r_valid;
    assign o_instret        = r_instret;

endmodule
`default_nettype wire
